// File: rtl/sreg_ser_tx_pkg.sv
// Shared definitions for the signed bit-serial link (transmitter and matching receiver).
//   ST_IDLE/ST_DATA/ST_PARITY : state encodings, also exposed as the typed enum state_e
//   cnt_w()                   : width of the per-word bit counter for a given data width
package sreg_ser_tx_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;

  typedef enum logic [1:0] {
    StIdle   = ST_IDLE,
    StData   = ST_DATA,
    StParity = ST_PARITY
  } state_e;

  // $clog2 of the data width; DATAWIDTH=2 still needs one counter bit.
  function automatic int unsigned cnt_w(input int unsigned width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/sreg_ser_tx_if.sv
// Load + serial handshake bundle for sreg_ser_tx.
//   d, load_valid, load_ready          : parallel word load port (valid/ready)
//   ser_out, ser_valid, ser_ready      : serial beat port (valid/ready)
//   ser_first, ser_last                : beat qualifiers (first data beat / final beat of a word)
//   busy                               : a word is in flight
// master = transmitter side, slave = the environment (word source and bit sink).
interface sreg_ser_tx_if #(
  parameter int unsigned DATAWIDTH = 8
) ();

  logic signed [DATAWIDTH-1:0] d;
  logic                        load_valid;
  logic                        load_ready;
  logic                        ser_out;
  logic                        ser_valid;
  logic                        ser_ready;
  logic                        ser_first;
  logic                        ser_last;
  logic                        busy;

  modport master (
    input  d, load_valid, ser_ready,
    output load_ready, ser_out, ser_valid, ser_first, ser_last, busy
  );

  modport slave (
    output d, load_valid, ser_ready,
    input  load_ready, ser_out, ser_valid, ser_first, ser_last, busy
  );

endinterface

// File: rtl/sreg_ser_tx.sv
// Signed parallel-to-serial transmitter.
// Accepts a DATAWIDTH-bit word on the load port and emits it one bit per beat on the serial
// port, MSB (sign) first or LSB first, optionally followed by one even-parity beat.
// Ports:
//   Clk  : clock, all state updates on posedge
//   Rst  : asynchronous active-low reset
//   bus  : sreg_ser_tx_if.master (load port, serial port, busy)
// Parameters:
//   DATAWIDTH : word width, 2..32
//   LSB_FIRST : 0 = MSB first, 1 = LSB first
//   PARITY_EN : 1 = append an even-parity beat after the data bits
module sreg_ser_tx
  import sreg_ser_tx_pkg::*;
#(
  parameter int unsigned DATAWIDTH = 8,
  parameter bit          LSB_FIRST = 1'b0,
  parameter bit          PARITY_EN = 1'b0
) (
  input  logic          Clk,
  input  logic          Rst,
  sreg_ser_tx_if.master bus
);

  localparam int unsigned    CntW    = cnt_w(DATAWIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(DATAWIDTH - 1);

  state_e                 state_q;
  logic [DATAWIDTH-1:0]   sreg_q;
  logic [CntW-1:0]        cnt_q;
  logic                   parity_q;

  logic                   ser_valid;
  logic                   ser_last;
  logic                   ser_first;
  logic                   ser_out;
  logic                   data_bit;
  logic [DATAWIDTH-1:0]   sreg_shift;
  logic                   xfer;
  logic                   load_ready;
  logic                   accept;

  // Outputs other than load_ready are decoded purely from flops.
  always_comb begin
    ser_valid = (state_q != StIdle);
    ser_first = (state_q == StData) && (cnt_q == '0);
    ser_last  = (state_q == StParity) ||
                ((state_q == StData) && (cnt_q == CntLast) && !PARITY_EN);

    if (LSB_FIRST) begin
      data_bit   = sreg_q[0];
      sreg_shift = sreg_q >> 1;
    end else begin
      data_bit   = sreg_q[DATAWIDTH-1];
      sreg_shift = sreg_q << 1;
    end

    unique case (state_q)
      StData:   ser_out = data_bit;
      StParity: ser_out = parity_q;
      default:  ser_out = 1'b0;
    endcase
  end

  // The final-beat term lets the next word load in the same cycle the current one ends.
  always_comb begin
    xfer       = ser_valid && bus.ser_ready;
    load_ready = (state_q == StIdle) || (xfer && ser_last);
    accept     = bus.load_valid && load_ready;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q  <= StIdle;
      sreg_q   <= '0;
      cnt_q    <= '0;
      parity_q <= 1'b0;
    end else if (accept) begin
      state_q  <= StData;
      sreg_q   <= bus.d;
      cnt_q    <= '0;
      parity_q <= ^bus.d;
    end else if (xfer) begin
      unique case (state_q)
        StData: begin
          sreg_q <= sreg_shift;
          if (cnt_q == CntLast) begin
            // Counter parks at CntLast; it is cleared by the next load.
            state_q <= PARITY_EN ? StParity : StIdle;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StParity: state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

  assign bus.load_ready = load_ready;
  assign bus.ser_out    = ser_out;
  assign bus.ser_valid  = ser_valid;
  assign bus.ser_first  = ser_first;
  assign bus.ser_last   = ser_last;
  assign bus.busy       = ser_valid;

endmodule
